// File: rtl/awg_param_ctrl_pkg.sv
// Shared constants and helpers for the AWG parameter controller:
// key indices, output widths, parameter limits and step decoding.
package awg_param_ctrl_pkg;

   localparam int KEY_NUM      = 7;
   localparam int KEY_FREQ_UP  = 0;
   localparam int KEY_FREQ_DN  = 1;
   localparam int KEY_AMP_UP   = 2;
   localparam int KEY_AMP_DN   = 3;
   localparam int KEY_PHASE_UP = 4;
   localparam int KEY_PHASE_DN = 5;
   localparam int KEY_RUN      = 6;

   localparam int FREQ_W  = 12;
   localparam int AMP_W   = 3;
   localparam int PHASE_W = 8;

   localparam logic [FREQ_W-1:0] FREQ_MIN = 12'd1;
   localparam logic [FREQ_W-1:0] FREQ_MAX = 12'd4095;
   localparam logic [AMP_W-1:0]  AMP_MAX  = 3'd7;

   typedef enum logic [1:0] {
      STEP_NONE,
      STEP_UP,
      STEP_DN
   } step_t;

   // Up and down in the same cycle cancel each other.
   function automatic step_t step_dir(input logic up, input logic dn);
      if (up && !dn) return STEP_UP;
      if (dn && !up) return STEP_DN;
      return STEP_NONE;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// One button: 2-flop synchronizer, debounce counter on the synchronized
// level, and a one-cycle pulse on each accepted press plus optional
// auto-repeat pulses while the key stays pressed.
module key_debounce
   import awg_param_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_DELAY    = 25_000_000,
   parameter int REPEAT_PERIOD   = 5_000_000,
   parameter bit REPEAT_EN       = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic pulse
);

   localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);

   logic             sync1, sync2, level;
   logic [DB_W-1:0]  db_cnt;
   logic [RPT_W-1:0] rpt_cnt, rpt_tgt;
   logic             rpt_first;
   logic             accept;

   // A level change is taken on the edge that sees the last of the
   // required consecutive differing samples.
   assign accept  = (sync2 != level) && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
   assign rpt_tgt = rpt_first ? RPT_W'(REPEAT_DELAY - 1) : RPT_W'(REPEAT_PERIOD - 1);

   // Synchronize the asynchronous button; idle (released) level is 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= key_n;
         sync2 <= sync1;
      end
   end

   // Debounce: any sample equal to the accepted level restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         db_cnt <= '0;
         level  <= 1'b1;
      end else if (sync2 == level) begin
         db_cnt <= '0;
      end else if (accept) begin
         level  <= sync2;
         db_cnt <= '0;
      end else begin
         db_cnt <= db_cnt + 1'b1;
      end
   end

   // Press pulse, then repeat pulses while held; a release (or reset)
   // clears the repeat timer.
   always_ff @(posedge clk) begin
      if (rst) begin
         pulse     <= 1'b0;
         rpt_cnt   <= '0;
         rpt_first <= 1'b1;
      end else begin
         pulse <= 1'b0;
         if (accept && !sync2) begin
            pulse     <= 1'b1;
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
         end else if (REPEAT_EN && !level && !accept) begin
            if (rpt_cnt == rpt_tgt) begin
               pulse     <= 1'b1;
               rpt_cnt   <= '0;
               rpt_first <= 1'b0;
            end else begin
               rpt_cnt <= rpt_cnt + 1'b1;
            end
         end else begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/awg_param_ctrl.sv
// AWG front-panel controller: seven debounced buttons adjust frequency,
// amplitude and phase registers and toggle the generator enable.
module awg_param_ctrl
   import awg_param_ctrl_pkg::*;
#(
   parameter int                 DEBOUNCE_CYCLES = 1_000_000,
   parameter int                 REPEAT_DELAY    = 25_000_000,
   parameter int                 REPEAT_PERIOD   = 5_000_000,
   parameter logic [FREQ_W-1:0]  FREQ_RST        = 12'd1,
   parameter logic [AMP_W-1:0]   AMP_RST         = 3'd7,
   parameter logic [PHASE_W-1:0] PHASE_RST       = 8'd0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [6:0]         key_n,
   output logic               en,
   output logic [FREQ_W-1:0]  state_freq,
   output logic [AMP_W-1:0]   state_amp,
   output logic [PHASE_W-1:0] state_phase,
   output logic               param_upd
);

   logic [KEY_NUM-1:0] press;
   logic [FREQ_W-1:0]  freq_nxt;
   logic [AMP_W-1:0]   amp_nxt;
   logic [PHASE_W-1:0] phase_nxt;
   logic               en_nxt;

   for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD),
         .REPEAT_EN       (i != KEY_RUN)
      ) u_key (
         .clk   (clk),
         .rst   (rst),
         .key_n (key_n[i]),
         .pulse (press[i])
      );
   end

   // Next values: saturating freq/amp, wrapping phase, toggling enable.
   always_comb begin
      freq_nxt  = state_freq;
      amp_nxt   = state_amp;
      phase_nxt = state_phase;
      en_nxt    = en ^ press[KEY_RUN];

      case (step_dir(press[KEY_FREQ_UP], press[KEY_FREQ_DN]))
         STEP_UP: if (state_freq != FREQ_MAX) freq_nxt = state_freq + 1'b1;
         STEP_DN: if (state_freq != FREQ_MIN) freq_nxt = state_freq - 1'b1;
         default: ;
      endcase

      case (step_dir(press[KEY_AMP_UP], press[KEY_AMP_DN]))
         STEP_UP: if (state_amp != AMP_MAX) amp_nxt = state_amp + 1'b1;
         STEP_DN: if (state_amp != '0)      amp_nxt = state_amp - 1'b1;
         default: ;
      endcase

      case (step_dir(press[KEY_PHASE_UP], press[KEY_PHASE_DN]))
         STEP_UP: phase_nxt = state_phase + 1'b1;
         STEP_DN: phase_nxt = state_phase - 1'b1;
         default: ;
      endcase
   end

   // Output registers; param_upd flags a real change only, so saturated
   // or cancelled steps stay silent.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_freq  <= FREQ_RST;
         state_amp   <= AMP_RST;
         state_phase <= PHASE_RST;
         en          <= 1'b1;
         param_upd   <= 1'b0;
      end else begin
         state_freq  <= freq_nxt;
         state_amp   <= amp_nxt;
         state_phase <= phase_nxt;
         en          <= en_nxt;
         param_upd   <= (freq_nxt != state_freq) || (amp_nxt != state_amp) ||
                        (phase_nxt != state_phase) || (en_nxt != en);
      end
   end

endmodule
